// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter that serialises NREQ memory requesters
// (I/D ports of each core) onto a single RAM port. One transaction at a time;
// each requester sees a combinational wait until its own access completes.
module mem_req_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    reqREN,
    input  logic [NREQ-1:0]    reqWEN,
    input  logic [NREQ*AW-1:0] reqaddr,
    input  logic [NREQ*DW-1:0] reqstore,
    output logic [DW-1:0]      reqload,
    output logic [NREQ-1:0]    reqwait,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic [1:0]         ramstate,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    output logic               err
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_grant, w_grant_nxt;
    logic [IW-1:0]   r_rr, w_rr_nxt;
    logic [IW-1:0]   w_sel;
    logic            w_any;
    logic [NREQ-1:0] w_req;
    logic            w_gren, w_gwen, w_greq, w_done;
    logic [AW-1:0]   w_gaddr;
    logic [DW-1:0]   w_gstore;

    assign w_req    = reqREN | reqWEN;
    assign grant_id = r_grant;

    // Round-robin pick: first requester at or above rr_ptr, then wrap to those below it
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && w_req[i] && (IW'(i) >= r_rr)) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && w_req[i] && (IW'(i) < r_rr)) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
    end

    // Mux the granted requester's live strobes, address and store data
    always_comb begin
        w_gren   = 1'b0;
        w_gwen   = 1'b0;
        w_gaddr  = '0;
        w_gstore = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == IW'(i)) begin
                w_gren   = reqREN[i];
                w_gwen   = reqWEN[i];
                w_gaddr  = reqaddr[i*AW +: AW];
                w_gstore = reqstore[i*DW +: DW];
            end
        end
    end

    assign w_greq = w_gren | w_gwen;
    assign w_done = (r_state == GRANT) && w_greq &&
                    ((ramstate == RS_ACCESS) || (ramstate == RS_ERROR));

    // RAM-side and requester-side outputs; everything idles to zero outside GRANT
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        busy     = 1'b0;
        err      = 1'b0;
        reqload  = '0;
        for (int i = 0; i < NREQ; i++)
            reqwait[i] = w_req[i] & ~(w_done && (r_grant == IW'(i)));
        if (r_state == GRANT) begin
            ramWEN   = w_gwen;
            ramREN   = w_gren & ~w_gwen;  // write wins when both strobes are set
            ramaddr  = w_gaddr;
            ramstore = w_gstore;
            busy     = 1'b1;
            if (w_done) begin
                reqload = ramload;
                err     = (ramstate == RS_ERROR);
            end
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until done or abort
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_sel;
                end
            end
            GRANT: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                    // completed requester drops to lowest priority
                    w_rr_nxt    = (r_grant == IW'(NREQ-1)) ? '0 : r_grant + IW'(1);
                end else if (!w_greq) begin
                    w_state_nxt = IDLE;  // abort keeps the old priority pointer
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, grant and priority registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

endmodule
